// File: rtl/ifetch_ctrl_pkg.sv
// Shared front-end definitions: fetch FSM states and the PC arithmetic
// constants used by the fetch controller and the next-PC selector.
package ifetch_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_DRAIN,
    ST_TRAP
  } fetch_state_e;

  localparam logic [31:0] CPU_NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_INCR       = 32'd4;
  localparam logic [31:0] ALIGN_MASK    = 32'hFFFF_FFFC;

endpackage

// File: rtl/ifetch_ctrl_pc_next_sel.sv
// Combinational next-PC selection: aligned redirect target, sequential PC+4,
// or hold. Also flags redirect targets whose bit 1 is set.
module pc_next_sel
  import ifetch_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            advance,
  output logic [XLEN-1:0] pc_next,
  output logic            misalign
);

  // Sign extension keeps the upper bits set should XLEN ever exceed 32.
  localparam logic [XLEN-1:0] MASK = XLEN'(signed'(ALIGN_MASK));

  always_comb begin
    misalign = redirect_valid && redirect_target[1];
    if (redirect_valid && !redirect_target[1]) begin
      pc_next = redirect_target & MASK;
    end else if (!redirect_valid && advance) begin
      pc_next = pc + XLEN'(PC_INCR);
    end else begin
      pc_next = pc;
    end
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: owns the PC, runs a single-outstanding
// IMEM request/response handshake and presents fetched words to decode.
module ifetch_ctrl
  import ifetch_ctrl_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(CPU_NOP_INSTR)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            REDIRECT_VALID,
  input  logic [XLEN-1:0] REDIRECT_TARGET,
  input  logic            STALL,
  output logic            IMEM_REQ,
  output logic [XLEN-1:0] IMEM_ADDR,
  input  logic            IMEM_GNT,
  input  logic            IMEM_RVALID,
  input  logic [XLEN-1:0] IMEM_RDATA,
  output logic            INSTR_VALID,
  output logic [XLEN-1:0] INSTR,
  output logic [XLEN-1:0] INSTR_PC,
  output logic            MISALIGN_EXC,
  output logic [XLEN-1:0] MISALIGN_ADDR
);

  fetch_state_e    state, state_next;
  logic [XLEN-1:0] pc, pc_next, req_addr;
  logic            misalign, deliver, drain_to_trap;

  assign deliver = (state == ST_WAIT) && IMEM_RVALID && !REDIRECT_VALID;

  pc_next_sel #(.XLEN(XLEN)) u_pc_next_sel (
    .pc              (pc),
    .redirect_valid  (REDIRECT_VALID),
    .redirect_target (REDIRECT_TARGET),
    .advance         (deliver),
    .pc_next         (pc_next),
    .misalign        (misalign)
  );

  // NOTE: reset is synchronous, so it lives inside the clocked block and every
  // state element is updated with non-blocking assignments only.
  always_ff @(posedge CLK) begin
    if (RST) state <= ST_REQ;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_REQ: begin
        if (REDIRECT_VALID)  state_next = misalign ? ST_TRAP : (IMEM_GNT ? ST_DRAIN : ST_REQ);
        else if (IMEM_GNT)   state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (REDIRECT_VALID)   state_next = misalign ? ST_TRAP : (IMEM_RVALID ? ST_REQ : ST_DRAIN);
        else if (IMEM_RVALID) state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (REDIRECT_VALID) state_next = misalign ? ST_TRAP : ST_REQ;
        else if (!STALL)    state_next = ST_REQ;
      end
      ST_DRAIN: begin
        // The most recent redirect decides where the drained FSM lands.
        if (IMEM_RVALID) begin
          if (REDIRECT_VALID) state_next = misalign ? ST_TRAP : ST_REQ;
          else                state_next = drain_to_trap ? ST_TRAP : ST_REQ;
        end
      end
      ST_TRAP: begin
        if (REDIRECT_VALID && !misalign) state_next = ST_REQ;
      end
      default: state_next = ST_REQ;
    endcase
  end

  always_comb begin
    IMEM_REQ  = (state == ST_REQ) && !RST;
    IMEM_ADDR = pc;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc            <= RESET_PC;
      req_addr      <= RESET_PC;
      drain_to_trap <= 1'b0;
      INSTR_VALID   <= 1'b0;
      INSTR         <= NOP_INSTR;
      INSTR_PC      <= '0;
      MISALIGN_EXC  <= 1'b0;
      MISALIGN_ADDR <= '0;
    end else begin
      pc <= pc_next;
      if (state == ST_REQ && IMEM_GNT && !REDIRECT_VALID) req_addr <= pc;

      if (state == ST_DRAIN && !IMEM_RVALID) begin
        if (REDIRECT_VALID) drain_to_trap <= misalign;
      end else begin
        drain_to_trap <= 1'b0;
      end

      if (REDIRECT_VALID) begin
        INSTR_VALID  <= 1'b0;
        INSTR        <= NOP_INSTR;
        MISALIGN_EXC <= misalign;
        if (misalign) MISALIGN_ADDR <= REDIRECT_TARGET;
      end else if (deliver) begin
        INSTR_VALID <= 1'b1;
        INSTR       <= IMEM_RDATA;
        INSTR_PC    <= req_addr;
      end else if (state == ST_HOLD && !STALL) begin
        INSTR_VALID <= 1'b0;
        INSTR       <= NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed, table-driven bench for ifetch_ctrl: each row drives one cycle of
// inputs and states the outputs expected during that cycle.
module tb_ifetch_ctrl;

  localparam logic [31:0] N = 32'h0000_0013;
  localparam logic [31:0] A = 32'hA5A5_0000;
  localparam logic [31:0] X = 32'h0000_0000;

  logic        CLK, RST, REDIRECT_VALID, STALL, IMEM_GNT, IMEM_RVALID;
  logic [31:0] REDIRECT_TARGET, IMEM_RDATA;
  logic        IMEM_REQ, INSTR_VALID, MISALIGN_EXC;
  logic [31:0] IMEM_ADDR, INSTR, INSTR_PC, MISALIGN_ADDR;

  ifetch_ctrl dut (
    .CLK             (CLK),
    .RST             (RST),
    .REDIRECT_VALID  (REDIRECT_VALID),
    .REDIRECT_TARGET (REDIRECT_TARGET),
    .STALL           (STALL),
    .IMEM_REQ        (IMEM_REQ),
    .IMEM_ADDR       (IMEM_ADDR),
    .IMEM_GNT        (IMEM_GNT),
    .IMEM_RVALID     (IMEM_RVALID),
    .IMEM_RDATA      (IMEM_RDATA),
    .INSTR_VALID     (INSTR_VALID),
    .INSTR           (INSTR),
    .INSTR_PC        (INSTR_PC),
    .MISALIGN_EXC    (MISALIGN_EXC),
    .MISALIGN_ADDR   (MISALIGN_ADDR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst, rv;
    logic [31:0] tgt;
    logic        stall, gnt, rval;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_instr, e_ipc;
    logic        e_exc;
    logic [31:0] e_eaddr;
  } vec_t;

  vec_t vecs[$];
  int   total  = 0;
  int   passed = 0;

  function automatic vec_t mk(logic rst, logic rv, logic [31:0] tgt, logic stall,
                              logic gnt, logic rval, logic [31:0] rdata,
                              logic e_req, logic [31:0] e_addr, logic e_val,
                              logic [31:0] e_instr, logic [31:0] e_ipc,
                              logic e_exc, logic [31:0] e_eaddr);
    vec_t v;
    v.rst = rst; v.rv = rv; v.tgt = tgt; v.stall = stall; v.gnt = gnt;
    v.rval = rval; v.rdata = rdata; v.e_req = e_req; v.e_addr = e_addr;
    v.e_val = e_val; v.e_instr = e_instr; v.e_ipc = e_ipc; v.e_exc = e_exc;
    v.e_eaddr = e_eaddr;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else             passed++;
  endtask

  // Drives a row just after a rising edge, samples mid-cycle, then steps.
  task automatic apply(input vec_t v, input string tag);
    RST = v.rst; REDIRECT_VALID = v.rv; REDIRECT_TARGET = v.tgt; STALL = v.stall;
    IMEM_GNT = v.gnt; IMEM_RVALID = v.rval; IMEM_RDATA = v.rdata;
    #3;
    check({tag, " req"}, 128'(IMEM_REQ), 128'(v.e_req));
    if (v.e_req) check({tag, " addr"}, 128'(IMEM_ADDR), 128'(v.e_addr));
    check({tag, " out"},
          128'({INSTR_VALID, INSTR, INSTR_PC, MISALIGN_EXC, MISALIGN_ADDR}),
          128'({v.e_val, v.e_instr, v.e_ipc, v.e_exc, v.e_eaddr}));
    @(posedge CLK);
    #2;
  endtask

  initial begin
    //                rst rv tgt            st gnt rv rdata            req addr           val instr          ipc            exc eaddr
    // Free run: GNT immediate, RVALID one cycle later.
    vecs.push_back(mk(0, 0, X,             0, 1, 0, X,               1, 32'h0,          0, N,             32'h0,         0, X));
    vecs.push_back(mk(0, 0, X,             0, 0, 1, A,               0, X,              0, N,             32'h0,         0, X));
    vecs.push_back(mk(0, 0, X,             0, 0, 0, X,               0, X,              1, A,             32'h0,         0, X));
    vecs.push_back(mk(0, 0, X,             0, 1, 0, X,               1, 32'h4,          0, N,             32'h0,         0, X));
    vecs.push_back(mk(0, 0, X,             0, 0, 1, A ^ 32'h4,       0, X,              0, N,             32'h0,         0, X));
    vecs.push_back(mk(0, 0, X,             0, 0, 0, X,               0, X,              1, A ^ 32'h4,     32'h4,         0, X));
    vecs.push_back(mk(0, 0, X,             0, 1, 0, X,               1, 32'h8,          0, N,             32'h4,         0, X));
    vecs.push_back(mk(0, 0, X,             0, 0, 1, A ^ 32'h8,       0, X,              0, N,             32'h4,         0, X));
    // HOLD at 0x8 with STALL for five cycles, then consumed.
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 0, X,           1, 1, 1, 32'h1111_1111,   0, X,              1, A ^ 32'h8,     32'h8,         0, X));
    vecs.push_back(mk(0, 0, X,             0, 0, 0, X,               0, X,              1, A ^ 32'h8,     32'h8,         0, X));
    vecs.push_back(mk(0, 0, X,             0, 1, 0, X,               1, 32'hC,          0, N,             32'h8,         0, X));
    // Redirect to 0x100 in WAIT; response drained three cycles later.
    vecs.push_back(mk(0, 1, 32'h100,       0, 0, 0, X,               0, X,              0, N,             32'h8,         0, X));
    vecs.push_back(mk(0, 0, X,             0, 0, 0, X,               0, X,              0, N,             32'h8,         0, X));
    vecs.push_back(mk(0, 0, X,             0, 0, 0, X,               0, X,              0, N,             32'h8,         0, X));
    vecs.push_back(mk(0, 0, X,             0, 0, 1, 32'hDEAD_BEEF,   0, X,              0, N,             32'h8,         0, X));
    vecs.push_back(mk(0, 0, X,             0, 1, 0, X,               1, 32'h100,        0, N,             32'h8,         0, X));
    vecs.push_back(mk(0, 0, X,             0, 0, 1, 32'h1234_5678,   0, X,              0, N,             32'h8,         0, X));
    // Misaligned redirect from HOLD, TRAP ignores memory, overwrite, then leave.
    vecs.push_back(mk(0, 1, 32'h202,       0, 0, 0, X,               0, X,              1, 32'h1234_5678, 32'h100,       0, X));
    vecs.push_back(mk(0, 0, X,             0, 1, 1, 32'h9999_9999,   0, X,              0, N,             32'h100,       1, 32'h202));
    vecs.push_back(mk(0, 1, 32'h206,       0, 0, 0, X,               0, X,              0, N,             32'h100,       1, 32'h202));
    vecs.push_back(mk(0, 1, 32'h300,       0, 0, 0, X,               0, X,              0, N,             32'h100,       1, 32'h206));
    vecs.push_back(mk(0, 0, X,             0, 0, 0, X,               1, 32'h300,        0, N,             32'h100,       0, 32'h206));
    vecs.push_back(mk(0, 0, X,             0, 1, 0, X,               1, 32'h300,        0, N,             32'h100,       0, 32'h206));
    vecs.push_back(mk(0, 0, X,             0, 0, 1, 32'hAAAA_0300,   0, X,              0, N,             32'h100,       0, 32'h206));
    vecs.push_back(mk(0, 0, X,             0, 0, 0, X,               0, X,              1, 32'hAAAA_0300, 32'h300,       0, 32'h206));
    // Redirect in REQ without GNT, then the wrap-around fetch at 0xFFFF_FFFC.
    vecs.push_back(mk(0, 1, 32'hFFFF_FFFC, 0, 0, 0, X,               1, 32'h304,        0, N,             32'h300,       0, 32'h206));
    vecs.push_back(mk(0, 0, X,             0, 1, 0, X,               1, 32'hFFFF_FFFC,  0, N,             32'h300,       0, 32'h206));
    vecs.push_back(mk(0, 0, X,             0, 0, 1, 32'h0BAD_F00C,   0, X,              0, N,             32'h300,       0, 32'h206));
    vecs.push_back(mk(0, 0, X,             0, 0, 0, X,               0, X,              1, 32'h0BAD_F00C, 32'hFFFF_FFFC, 0, 32'h206));
    // Redirect with RVALID in WAIT, then redirect with GNT in REQ.
    vecs.push_back(mk(0, 0, X,             0, 1, 0, X,               1, 32'h0,          0, N,             32'hFFFF_FFFC, 0, 32'h206));
    vecs.push_back(mk(0, 1, 32'h41,        0, 0, 1, 32'h55,          0, X,              0, N,             32'hFFFF_FFFC, 0, 32'h206));
    vecs.push_back(mk(0, 1, 32'h80,        0, 1, 0, X,               1, 32'h40,         0, N,             32'hFFFF_FFFC, 0, 32'h206));
    vecs.push_back(mk(0, 0, X,             0, 0, 1, 32'h77,          0, X,              0, N,             32'hFFFF_FFFC, 0, 32'h206));
    vecs.push_back(mk(0, 0, X,             0, 1, 0, X,               1, 32'h80,         0, N,             32'hFFFF_FFFC, 0, 32'h206));
    // Misaligned redirect while draining: flagged at once, TRAP after the drain.
    vecs.push_back(mk(0, 1, 32'h500,       0, 0, 0, X,               0, X,              0, N,             32'hFFFF_FFFC, 0, 32'h206));
    vecs.push_back(mk(0, 1, 32'h602,       0, 0, 0, X,               0, X,              0, N,             32'hFFFF_FFFC, 0, 32'h206));
    vecs.push_back(mk(0, 0, X,             0, 0, 1, 32'h88,          0, X,              0, N,             32'hFFFF_FFFC, 1, 32'h602));
    vecs.push_back(mk(0, 0, X,             0, 1, 0, X,               0, X,              0, N,             32'hFFFF_FFFC, 1, 32'h602));
    vecs.push_back(mk(0, 1, 32'h10,        0, 0, 0, X,               0, X,              0, N,             32'hFFFF_FFFC, 1, 32'h602));

    RST = 1'b1; REDIRECT_VALID = 1'b0; REDIRECT_TARGET = '0; STALL = 1'b0;
    IMEM_GNT = 1'b0; IMEM_RVALID = 1'b0; IMEM_RDATA = '0;
    @(posedge CLK);
    #2;
    check("reset addr", 128'(IMEM_ADDR), 128'(32'h0));
    apply(mk(1, 0, X, 0, 1, 1, X, 0, X, 0, N, 32'h0, 0, X), "reset");

    foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

    // Reset in the middle of a WAIT; the stale response must be ignored.
    apply(mk(0, 0, X, 0, 1, 0, X,             1, 32'h10, 0, N,     32'hFFFF_FFFC, 0, 32'h602), "h0");
    apply(mk(1, 0, X, 0, 0, 0, X,             0, X,      0, N,     32'hFFFF_FFFC, 0, 32'h602), "h1");
    apply(mk(0, 0, X, 0, 0, 0, X,             1, 32'h0,  0, N,     32'h0,         0, X),         "h2");
    apply(mk(0, 0, X, 0, 0, 1, 32'hDEAD_DEAD, 1, 32'h0,  0, N,     32'h0,         0, X),         "h3");
    apply(mk(0, 0, X, 0, 1, 0, X,             1, 32'h0,  0, N,     32'h0,         0, X),         "h4");
    apply(mk(0, 0, X, 0, 0, 1, 32'h111,       0, X,      0, N,     32'h0,         0, X),         "h5");
    apply(mk(0, 0, X, 0, 0, 0, X,             0, X,      1, 32'h111, 32'h0,       0, X),         "h6");
    apply(mk(0, 0, X, 0, 0, 0, X,             1, 32'h4,  0, N,     32'h0,         0, X),         "h7");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
